// File: rtl/iir_mac_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : iir_mac_scheduler_if
// Description : Control bus between the IIR MAC scheduler and the sample
//               source / filter datapath. The master side is the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface iir_mac_scheduler_if #(
  parameter int TAPS = 5,
  parameter int TW   = $clog2(TAPS)
);
  logic          filter_rst;
  logic          sample_valid;
  logic          sample_ready;
  logic          mac_clr;
  logic          mac_en;
  logic [TW:0]   coef_addr;
  logic [TW-1:0] data_sel;
  logic          chan;
  logic          result_valid;
  logic          result_chan;
  logic          hist_shift;
  logic          hist_clr;
  logic          busy;
  logic          overrun;

  // Scheduler side
  modport master (
    input  filter_rst, sample_valid,
    output sample_ready, mac_clr, mac_en, coef_addr, data_sel, chan,
           result_valid, result_chan, hist_shift, hist_clr, busy, overrun
  );

  // Sample source / datapath side
  modport slave (
    output filter_rst, sample_valid,
    input  sample_ready, mac_clr, mac_en, coef_addr, data_sel, chan,
           result_valid, result_chan, hist_shift, hist_clr, busy, overrun
  );
endinterface
`default_nettype wire

// File: rtl/iir_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : iir_mac_scheduler
// Description : Time-shares one MAC between the low-pass (chan 0) and
//               high-pass (chan 1) biquad sections. Every accepted sample
//               runs CLR/RUN/DRAIN/EMIT for chan 0, then for chan 1.
//               All outputs are registers loaded from the next-state decode,
//               so no input reaches an output combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module iir_mac_scheduler #(
  parameter int TAPS    = 5,
  parameter int MAC_LAT = 2,
  parameter int TW      = $clog2(TAPS)
) (
  input logic                 clk,
  input logic                 rst,
  iir_mac_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_EMIT  = 3'd4
  } state_t;

  localparam logic [TW-1:0] LAST_TAP     = TW'(TAPS - 1);
  // The drain counter is loaded with MAC_LAT-1 so DRAIN lasts MAC_LAT cycles
  localparam int            DRAIN_RELOAD = (MAC_LAT > 0) ? (MAC_LAT - 1) : 0;
  localparam logic [2:0]    DRAIN_INIT   = 3'(DRAIN_RELOAD);

  state_t        state_q, state_d;
  logic          chan_q, chan_d;
  logic [TW-1:0] tap_q, tap_d;
  logic [2:0]    cnt_q, cnt_d;

  logic          sample_ready_q;
  logic          mac_clr_q;
  logic          mac_en_q;
  logic [TW:0]   coef_addr_q;
  logic [TW-1:0] data_sel_q;
  logic          emit_q;
  logic          result_chan_q;
  logic          hist_clr_q;
  logic          busy_q;
  logic          overrun_q;

  logic          accept;

  // sample_ready_q already implies IDLE with history not being cleared
  assign accept = bus.sample_valid && sample_ready_q;

  // Next-state decode; filter_rst overrides every transition including accept
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    tap_d   = tap_q;
    cnt_d   = cnt_q;
    if (bus.filter_rst) begin
      state_d = S_IDLE;
      chan_d  = 1'b0;
      tap_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_d = S_CLR;
            chan_d  = 1'b0;
          end
        end
        S_CLR: begin
          tap_d   = '0;
          state_d = S_RUN;
        end
        S_RUN: begin
          if (tap_q == LAST_TAP) begin
            tap_d = '0;
            if (MAC_LAT == 0) begin
              state_d = S_EMIT;
            end else begin
              state_d = S_DRAIN;
              cnt_d   = DRAIN_INIT;
            end
          end else begin
            tap_d = tap_q + TW'(1);
          end
        end
        S_DRAIN: begin
          if (cnt_q == 3'd0) state_d = S_EMIT;
          else               cnt_d   = cnt_q - 3'd1;
        end
        S_EMIT: begin
          // chan flips only on the EMIT exit edge
          if (!chan_q) begin
            chan_d  = 1'b1;
            state_d = S_CLR;
          end else begin
            chan_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          chan_d  = 1'b0;
          tap_d   = '0;
        end
      endcase
    end
  end

  // State registers plus Moore outputs registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      chan_q         <= 1'b0;
      tap_q          <= '0;
      cnt_q          <= '0;
      sample_ready_q <= 1'b0;
      mac_clr_q      <= 1'b0;
      mac_en_q       <= 1'b0;
      coef_addr_q    <= '0;
      data_sel_q     <= '0;
      emit_q         <= 1'b0;
      result_chan_q  <= 1'b0;
      hist_clr_q     <= 1'b1;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      chan_q         <= chan_d;
      tap_q          <= tap_d;
      cnt_q          <= cnt_d;
      hist_clr_q     <= bus.filter_rst;
      sample_ready_q <= (state_d == S_IDLE) && !bus.filter_rst;
      mac_clr_q      <= (state_d == S_CLR);
      mac_en_q       <= (state_d == S_RUN);
      coef_addr_q    <= (state_d == S_RUN) ? {chan_d, tap_d} : '0;
      data_sel_q     <= (state_d == S_RUN) ? tap_d : '0;
      emit_q         <= (state_d == S_EMIT);
      result_chan_q  <= (state_d == S_EMIT) ? chan_d : 1'b0;
      busy_q         <= (state_d != S_IDLE);
      // Overrun is sticky; a sample offered while busy is dropped, not queued
      if (bus.filter_rst)
        overrun_q <= 1'b0;
      else if (bus.sample_valid && (state_q != S_IDLE))
        overrun_q <= 1'b1;
    end
  end

  assign bus.sample_ready = sample_ready_q;
  assign bus.mac_clr      = mac_clr_q;
  assign bus.mac_en       = mac_en_q;
  assign bus.coef_addr    = coef_addr_q;
  assign bus.data_sel     = data_sel_q;
  assign bus.chan         = chan_q;
  assign bus.result_valid = emit_q;
  assign bus.result_chan  = result_chan_q;
  assign bus.hist_shift   = emit_q;
  assign bus.hist_clr     = hist_clr_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_iir_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_iir_mac_scheduler
// Description : Directed self-checking bench for iir_mac_scheduler, one
//               default instance (TAPS=5, MAC_LAT=2) and one swept instance
//               (TAPS=3, MAC_LAT=0). Cycle 0 is the cycle whose closing edge
//               accepts the sample; cycle k is observed 1 ns after edge k-1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iir_mac_scheduler;

  logic clk = 1'b0;
  logic rst;
  logic frst;
  logic sv0;
  logic sv1;
  int   n_checks = 0;
  int   n_fail   = 0;

  iir_mac_scheduler_if #(.TAPS(5)) bus0 ();
  iir_mac_scheduler_if #(.TAPS(3)) bus1 ();

  assign bus0.filter_rst   = frst;
  assign bus0.sample_valid = sv0;
  assign bus1.filter_rst   = frst;
  assign bus1.sample_valid = sv1;

  iir_mac_scheduler #(.TAPS(5), .MAC_LAT(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  iir_mac_scheduler #(.TAPS(3), .MAC_LAT(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // 20 ns clock, rising edges at 10, 30, 50 ...
  always #10 clk = ~clk;

  // Bounded wait for sample_ready; returns aligned 1 ns after an edge
  task automatic wait_ready(input bit which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if ((which ? bus1.sample_ready : bus0.sample_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; frst = 1'b1; sv0 = 1'b0; sv1 = 1'b0;
    #5;
    n_checks++; if (bus0.sample_ready !== 1'b0) begin n_fail++; $display("FAIL reset ready got %b exp 0", bus0.sample_ready); end
    n_checks++; if (bus0.hist_clr !== 1'b1) begin n_fail++; $display("FAIL reset hist_clr got %b exp 1", bus0.hist_clr); end
    n_checks++; if (bus0.busy !== 1'b0 || bus0.chan !== 1'b0 || bus0.overrun !== 1'b0) begin n_fail++; $display("FAIL reset busy/chan/ovr got %b%b%b exp 000", bus0.busy, bus0.chan, bus0.overrun); end
    n_checks++; if (bus0.mac_en !== 1'b0 || bus0.mac_clr !== 1'b0 || bus0.result_valid !== 1'b0 || bus0.coef_addr !== 4'd0) begin n_fail++; $display("FAIL reset strobes not zero"); end
    #10 rst = 1'b0;          // t=15
    #16;                     // t=31, filter_rst sampled high at 30
    n_checks++; if (bus0.hist_clr !== 1'b1) begin n_fail++; $display("FAIL rel hist_clr got %b exp 1", bus0.hist_clr); end
    n_checks++; if (bus0.sample_ready !== 1'b0) begin n_fail++; $display("FAIL rel ready got %b exp 0", bus0.sample_ready); end
    #4 frst = 1'b0;          // t=35
    #16;                     // t=51, filter_rst sampled low at 50
    n_checks++; if (bus0.hist_clr !== 1'b0) begin n_fail++; $display("FAIL rel2 hist_clr got %b exp 0", bus0.hist_clr); end
    n_checks++; if (bus0.sample_ready !== 1'b1) begin n_fail++; $display("FAIL rel2 ready got %b exp 1", bus0.sample_ready); end
    n_checks++; if (bus1.sample_ready !== 1'b1) begin n_fail++; $display("FAIL rel2 ready1 got %b exp 1", bus1.sample_ready); end
  endtask

  task automatic test_single;
    bit ok;
    logic e_clr, e_en, e_rv, e_rc, e_chan, e_rdy, e_busy;
    logic [3:0] e_addr;
    logic [2:0] e_sel;
    int e_tap;
    wait_ready(1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single timeout waiting sample_ready"); end
    sv0 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      sv0 = 1'b0;
      e_clr  = (c == 1) || (c == 10);
      e_en   = (c >= 2 && c <= 6) || (c >= 11 && c <= 15);
      e_tap  = (c <= 6) ? c - 2 : c - 11;
      e_addr = e_en ? 4'(((c >= 11) ? 8 : 0) + e_tap) : 4'd0;
      e_sel  = e_en ? 3'(e_tap) : 3'd0;
      e_rv   = (c == 9) || (c == 18);
      e_rc   = (c == 18);
      e_chan = (c >= 10 && c <= 18);
      e_rdy  = (c >= 19);
      e_busy = (c <= 18);
      n_checks++; if (bus0.mac_clr !== e_clr) begin n_fail++; $display("FAIL single c=%0d mac_clr got %b exp %b", c, bus0.mac_clr, e_clr); end
      n_checks++; if (bus0.mac_en !== e_en) begin n_fail++; $display("FAIL single c=%0d mac_en got %b exp %b", c, bus0.mac_en, e_en); end
      n_checks++; if (bus0.coef_addr !== e_addr) begin n_fail++; $display("FAIL single c=%0d coef_addr got %0d exp %0d", c, bus0.coef_addr, e_addr); end
      n_checks++; if (bus0.data_sel !== e_sel) begin n_fail++; $display("FAIL single c=%0d data_sel got %0d exp %0d", c, bus0.data_sel, e_sel); end
      n_checks++; if (bus0.result_valid !== e_rv) begin n_fail++; $display("FAIL single c=%0d result_valid got %b exp %b", c, bus0.result_valid, e_rv); end
      n_checks++; if (bus0.hist_shift !== e_rv) begin n_fail++; $display("FAIL single c=%0d hist_shift got %b exp %b", c, bus0.hist_shift, e_rv); end
      n_checks++; if (bus0.result_chan !== e_rc) begin n_fail++; $display("FAIL single c=%0d result_chan got %b exp %b", c, bus0.result_chan, e_rc); end
      n_checks++; if (bus0.chan !== e_chan) begin n_fail++; $display("FAIL single c=%0d chan got %b exp %b", c, bus0.chan, e_chan); end
      n_checks++; if (bus0.sample_ready !== e_rdy) begin n_fail++; $display("FAIL single c=%0d ready got %b exp %b", c, bus0.sample_ready, e_rdy); end
      n_checks++; if (bus0.busy !== e_busy) begin n_fail++; $display("FAIL single c=%0d busy got %b exp %b", c, bus0.busy, e_busy); end
    end
  endtask

  // mode 0: pulse sample_valid at 0/19/38; mode 1: hold it high through 38
  task automatic test_back_to_back;
    bit ok;
    logic e_clr, e_rdy, e_ov;
    for (int mode = 0; mode < 2; mode++) begin
      wait_ready(1'b0, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b mode=%0d timeout waiting sample_ready", mode); end
      sv0 = 1'b1;
      for (int c = 1; c <= 57; c++) begin
        @(posedge clk); #1;
        if (mode == 0) sv0 = (c == 19) || (c == 38);
        else           sv0 = (c <= 38);
        e_clr = (c == 1) || (c == 10) || (c == 20) || (c == 29) || (c == 39) || (c == 48);
        e_rdy = (c == 19) || (c == 38) || (c == 57);
        e_ov  = (mode == 1) && (c >= 2);
        n_checks++; if (bus0.mac_clr !== e_clr) begin n_fail++; $display("FAIL b2b mode=%0d c=%0d mac_clr got %b exp %b", mode, c, bus0.mac_clr, e_clr); end
        n_checks++; if (bus0.sample_ready !== e_rdy) begin n_fail++; $display("FAIL b2b mode=%0d c=%0d ready got %b exp %b", mode, c, bus0.sample_ready, e_rdy); end
        n_checks++; if (bus0.overrun !== e_ov) begin n_fail++; $display("FAIL b2b mode=%0d c=%0d overrun got %b exp %b", mode, c, bus0.overrun, e_ov); end
      end
      sv0 = 1'b0;
      frst = 1'b1;
      @(posedge clk); #1;
      frst = 1'b0;
      n_checks++; if (bus0.overrun !== 1'b0) begin n_fail++; $display("FAIL b2b mode=%0d overrun after filter_rst got %b exp 0", mode, bus0.overrun); end
    end
  endtask

  task automatic test_overrun;
    bit ok;
    logic e_clr, e_rv, e_ov;
    wait_ready(1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ovr timeout waiting sample_ready"); end
    sv0 = 1'b1;
    for (int c = 1; c <= 38; c++) begin
      @(posedge clk); #1;
      sv0   = (c == 5);
      e_clr = (c == 1) || (c == 10);
      e_rv  = (c == 9) || (c == 18);
      e_ov  = (c >= 6);
      n_checks++; if (bus0.mac_clr !== e_clr) begin n_fail++; $display("FAIL ovr c=%0d mac_clr got %b exp %b", c, bus0.mac_clr, e_clr); end
      n_checks++; if (bus0.result_valid !== e_rv) begin n_fail++; $display("FAIL ovr c=%0d result_valid got %b exp %b", c, bus0.result_valid, e_rv); end
      n_checks++; if (bus0.overrun !== e_ov) begin n_fail++; $display("FAIL ovr c=%0d overrun got %b exp %b", c, bus0.overrun, e_ov); end
    end
    frst = 1'b1;
    @(posedge clk); #1;
    frst = 1'b0;
    n_checks++; if (bus0.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr clear got %b exp 0", bus0.overrun); end
    n_checks++; if (bus0.hist_clr !== 1'b1) begin n_fail++; $display("FAIL ovr hist_clr got %b exp 1", bus0.hist_clr); end
  endtask

  task automatic test_abort;
    bit ok;
    wait_ready(1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL abort timeout waiting sample_ready"); end
    sv0 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      sv0  = 1'b0;
      frst = (c == 12);
      if (c == 12) begin
        n_checks++; if (bus0.mac_en !== 1'b1 || bus0.coef_addr !== 4'd9) begin n_fail++; $display("FAIL abort c=12 mac_en/addr got %b/%0d exp 1/9", bus0.mac_en, bus0.coef_addr); end
      end
      if (c == 13) begin
        n_checks++; if (bus0.busy !== 1'b0 || bus0.chan !== 1'b0 || bus0.mac_en !== 1'b0) begin n_fail++; $display("FAIL abort c=13 busy/chan/en got %b%b%b exp 000", bus0.busy, bus0.chan, bus0.mac_en); end
        n_checks++; if (bus0.hist_clr !== 1'b1 || bus0.sample_ready !== 1'b0) begin n_fail++; $display("FAIL abort c=13 hist_clr/ready got %b/%b exp 1/0", bus0.hist_clr, bus0.sample_ready); end
      end
      if (c == 14) begin
        n_checks++; if (bus0.sample_ready !== 1'b1 || bus0.hist_clr !== 1'b0) begin n_fail++; $display("FAIL abort c=14 ready/hist_clr got %b/%b exp 1/0", bus0.sample_ready, bus0.hist_clr); end
      end
      if (c >= 13) begin
        n_checks++; if (bus0.result_valid !== 1'b0 || bus0.hist_shift !== 1'b0) begin n_fail++; $display("FAIL abort c=%0d result_valid/hist_shift got %b/%b exp 0/0", c, bus0.result_valid, bus0.hist_shift); end
      end
    end
  endtask

  task automatic test_param_sweep;
    bit ok;
    logic e_en, e_rv, e_rc, e_rdy;
    logic [2:0] e_addr;
    wait_ready(1'b1, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL sweep timeout waiting sample_ready"); end
    sv1 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      sv1    = 1'b0;
      e_en   = (c >= 2 && c <= 4) || (c >= 7 && c <= 9);
      e_addr = !e_en ? 3'd0 : (c >= 7) ? 3'(4 + c - 7) : 3'(c - 2);
      e_rv   = (c == 5) || (c == 10);
      e_rc   = (c == 10);
      e_rdy  = (c >= 11);
      n_checks++; if (bus1.mac_en !== e_en) begin n_fail++; $display("FAIL sweep c=%0d mac_en got %b exp %b", c, bus1.mac_en, e_en); end
      n_checks++; if (bus1.coef_addr !== e_addr) begin n_fail++; $display("FAIL sweep c=%0d coef_addr got %0d exp %0d", c, bus1.coef_addr, e_addr); end
      n_checks++; if (bus1.result_valid !== e_rv || bus1.result_chan !== e_rc) begin n_fail++; $display("FAIL sweep c=%0d rv/rc got %b/%b exp %b/%b", c, bus1.result_valid, bus1.result_chan, e_rv, e_rc); end
      n_checks++; if (bus1.sample_ready !== e_rdy) begin n_fail++; $display("FAIL sweep c=%0d ready got %b exp %b", c, bus1.sample_ready, e_rdy); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
